imm_gen_pipe: RTL

//  Pipelined, parametrised RV32/RV64 immediate generator for the decode stage. Accepts a 32-bit

---
 rtl/imm_gen_pipe_pkg.sv | 39 +++
 rtl/imm_gen_pipe_imm_decode.sv | 37 +++
 rtl/imm_gen_pipe.sv | 113 +++++++++++
 3 files changed

// File: rtl/imm_gen_pipe_pkg.sv
// Shared definitions for the pipelined immediate generator: opcodes, format
// encoding and the opcode-to-format classifier, which also decides legality.
package imm_gen_pipe_pkg;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_type_t;

    // IMM_NONE doubles as the "illegal opcode" class; addiw needs a 64-bit datapath.
    function automatic imm_type_t opcode_class(input logic [6:0] op, input int xlen);
        imm_type_t cls;
        case (op)
            OP_IMM, OP_LOAD, OP_JALR: cls = IMM_I;
            OP_IMM32:                 cls = (xlen == 64) ? IMM_I : IMM_NONE;
            OP_STORE:                 cls = IMM_S;
            OP_BRANCH:                cls = IMM_B;
            OP_LUI, OP_AUIPC:         cls = IMM_U;
            OP_JAL:                   cls = IMM_J;
            default:                  cls = IMM_NONE;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/imm_gen_pipe_imm_decode.sv
// Combinational RV32/RV64 immediate decoder: instruction word to sign-extended
// immediate, format class and illegal flag.
module imm_decode
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     instr_i,
    output logic [XLEN-1:0] imm_o,
    output logic [2:0]      type_o,
    output logic            illegal_o
);

    imm_type_t   cls_s;
    logic [63:0] imm64_s;

    // Build the full 64-bit sign-extended value, then keep the low XLEN bits.
    always_comb begin
        cls_s   = opcode_class(instr_i[6:0], XLEN);
        imm64_s = 64'd0;
        case (cls_s)
            IMM_I:   imm64_s = {{52{instr_i[31]}}, instr_i[31:20]};
            IMM_S:   imm64_s = {{52{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B:   imm64_s = {{51{instr_i[31]}}, instr_i[31], instr_i[7],
                                instr_i[30:25], instr_i[11:8], 1'b0};
            IMM_U:   imm64_s = {{32{instr_i[31]}}, instr_i[31:12], 12'd0};
            IMM_J:   imm64_s = {{43{instr_i[31]}}, instr_i[31], instr_i[19:12],
                                instr_i[20], instr_i[30:21], 1'b0};
            default: imm64_s = 64'd0;
        endcase
    end

    assign imm_o     = imm64_s[XLEN-1:0];
    assign type_o    = cls_s;
    assign illegal_o = (cls_s == IMM_NONE);

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decode in front of a STAGES-deep valid/ready
// register chain with bubble collapsing, flush and tag passthrough.
module imm_gen_pipe
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int STAGES = 2,
    parameter int TAG_W  = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_type,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    logic [XLEN-1:0]  dec_imm_s;
    logic [2:0]       dec_type_s;
    logic             dec_illegal_s;
    logic             accept_s;

    logic [STAGES-1:0] valid_q;
    logic [XLEN-1:0]   imm_q     [STAGES];
    logic [2:0]        type_q    [STAGES];
    logic [STAGES-1:0] illegal_q;
    logic [TAG_W-1:0]  tag_q     [STAGES];

    logic [STAGES-1:0] load_s;
    logic [STAGES-1:0] valid_d;
    logic [XLEN-1:0]   imm_d     [STAGES];
    logic [2:0]        type_d    [STAGES];
    logic [STAGES-1:0] illegal_d;
    logic [TAG_W-1:0]  tag_d     [STAGES];

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr_i   (in_instr),
        .imm_o     (dec_imm_s),
        .type_o    (dec_type_s),
        .illegal_o (dec_illegal_s)
    );

    // A stage may load when it is empty or its content moves on; walked from the output back.
    always_comb begin
        load_s = '0;
        load_s[STAGES-1] = !valid_q[STAGES-1] || out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            load_s[k] = !valid_q[k] || load_s[k+1];
        end
    end

    assign in_ready = load_s[0] && !flush;
    assign accept_s = in_valid && in_ready;

    // Each stage's input is the decoder (stage 0) or the previous stage.
    always_comb begin
        valid_d      = '0;
        illegal_d    = '0;
        valid_d[0]   = accept_s;
        imm_d[0]     = dec_imm_s;
        type_d[0]    = dec_type_s;
        illegal_d[0] = dec_illegal_s;
        tag_d[0]     = in_tag;
        for (int k = 1; k < STAGES; k++) begin
            valid_d[k]   = valid_q[k-1];
            imm_d[k]     = imm_q[k-1];
            type_d[k]    = type_q[k-1];
            illegal_d[k] = illegal_q[k-1];
            tag_d[k]     = tag_q[k-1];
        end
    end

    // Pipeline registers; data only updates with a valid entry so idle outputs hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= '0;
            illegal_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                imm_q[k]  <= '0;
                type_q[k] <= 3'd0;
                tag_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (flush) begin
                    valid_q[k] <= 1'b0;
                end else if (load_s[k]) begin
                    valid_q[k] <= valid_d[k];
                    if (valid_d[k]) begin
                        imm_q[k]     <= imm_d[k];
                        type_q[k]    <= type_d[k];
                        illegal_q[k] <= illegal_d[k];
                        tag_q[k]     <= tag_d[k];
                    end
                end
            end
        end
    end

    assign out_valid   = valid_q[STAGES-1];
    assign out_imm     = imm_q[STAGES-1];
    assign out_type    = type_q[STAGES-1];
    assign out_illegal = illegal_q[STAGES-1];
    assign out_tag     = tag_q[STAGES-1];

endmodule
